// File: rtl/clz_unit.sv
// Iterative leading-zero / leading-one counter.
// The operand is scanned MSB-first, CHUNK bits per clock. CLO mode stores the
// operand inverted so a single zero-counting datapath serves both modes.
module clz_unit #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MODE,
  input  logic [WIDTH-1:0] DATA_IN,
  output logic             BUSY,
  output logic             DONE,
  output logic [31:0]      RESULT
);

  // One extra bit so that a full-width count (all zero) is representable.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  // Count value at which the shift register's top chunk is the operand's last chunk.
  localparam logic [CNT_W-1:0] LAST_BASE = CNT_W'(WIDTH - CHUNK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_FIN  = 2'd2
  } state_t;

  state_t             state_r;
  logic [WIDTH-1:0]   shift_r;
  logic [CNT_W-1:0]   count_r;
  logic               busy_r;
  logic               done_r;
  logic [31:0]        result_r;

  logic [CHUNK-1:0]   top_chunk_s;
  logic [CNT_W-1:0]   chunk_lz_s;
  logic [CNT_W-1:0]   count_next_s;
  logic               chunk_zero_s;
  logic               last_chunk_s;

  // Leading-zero count of one chunk; an all-zero chunk yields CHUNK.
  function automatic logic [CNT_W-1:0] chunk_lzc(input logic [CHUNK-1:0] c);
    logic [CNT_W-1:0] n;
    logic             hit;
    n   = '0;
    hit = 1'b0;
    for (int i = CHUNK - 1; i >= 0; i--) begin
      if (c[i]) begin
        hit = 1'b1;
      end else if (!hit) begin
        n = n + CNT_W'(1);
      end else begin
        n = n;
      end
    end
    return n;
  endfunction

  // Examine the top chunk of the shift register and form the next count.
  always_comb begin
    top_chunk_s  = shift_r[WIDTH-1 -: CHUNK];
    chunk_lz_s   = chunk_lzc(top_chunk_s);
    count_next_s = count_r + chunk_lz_s;
    chunk_zero_s = (top_chunk_s == '0);
    last_chunk_s = (count_r == LAST_BASE);
  end

  // Control FSM with datapath and registered status/result outputs.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r  <= ST_IDLE;
      shift_r  <= '0;
      count_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      result_r <= 32'd0;
    end else begin
      case (state_r)
        ST_IDLE, ST_FIN: begin
          if (START) begin
            shift_r <= MODE ? ~DATA_IN : DATA_IN;
            count_r <= '0;
            state_r <= ST_SCAN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        ST_SCAN: begin
          // START is deliberately ignored here: the operand is already captured.
          if (chunk_zero_s && !last_chunk_s) begin
            count_r <= count_next_s;
            shift_r <= shift_r << CHUNK;
            state_r <= ST_SCAN;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end else begin
            count_r  <= count_next_s;
            result_r <= {{(32 - CNT_W){1'b0}}, count_next_s};
            state_r  <= ST_FIN;
            busy_r   <= 1'b0;
            done_r   <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign BUSY   = busy_r;
  assign DONE   = done_r;
  assign RESULT = result_r;

endmodule
